// File: rtl/gelato_warp_fetch_arbiter.sv
// Round-robin warp arbiter between the PC table and instruction fetch. It tracks each warp's in-flight fetch and re-arms the warp when its completion token returns.
// Optional perf counters are enabled with `define GELATO_FETCHARB_PERF_EN.
module gelato_warp_fetch_arbiter #(
    parameter int WARP_NUM    = 8,
    parameter int PC_WIDTH    = 32,
    parameter int SPLIT_WIDTH = 4,
    localparam int WID_WIDTH  = $clog2(WARP_NUM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rdy,
    input  logic [WARP_NUM-1:0]             warp_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]    warp_pc,
    input  logic [WARP_NUM*SPLIT_WIDTH-1:0] warp_split,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PC_WIDTH-1:0]             out_pc,
    output logic [WID_WIDTH-1:0]            out_warp,
    output logic [SPLIT_WIDTH-1:0]          out_split,
    input  logic                            done_valid,
    input  logic [WID_WIDTH-1:0]            done_warp,
    output logic [WARP_NUM-1:0]             inflight
`ifdef GELATO_FETCHARB_PERF_EN
   ,output logic [31:0]                     perf_issue_cnt,
    output logic [31:0]                     perf_stall_cnt
`endif
);

    // Handshake: an issue transfers on a clock edge where out_valid && out_ready.
    // While out_valid is high and out_ready low, every out_* signal stays stable.

    logic                   out_valid_q, out_valid_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
    logic [WID_WIDTH-1:0]   out_warp_q, out_warp_d;
    logic [SPLIT_WIDTH-1:0] out_split_q, out_split_d;
    logic [WARP_NUM-1:0]    pending_q, pending_d;
    logic [WID_WIDTH-1:0]   last_grant_q, last_grant_d;

    logic [WARP_NUM-1:0]    eligible;
    logic                   load_slot;
    logic                   done_hit;
    logic                   sel_found;
    logic [WID_WIDTH-1:0]   sel_idx;
    int                     cand;

    assign eligible  = warp_valid & ~pending_q;
    assign load_slot = rdy && (!out_valid_q || out_ready);
    assign done_hit  = done_valid && (32'(done_warp) < WARP_NUM);

    // Rotating search: last_grant+1 first, last_grant itself last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= WARP_NUM; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= WARP_NUM) begin
                cand = cand - WARP_NUM;
            end
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = WID_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_warp_d   = out_warp_q;
        out_split_d  = out_split_q;
        last_grant_d = last_grant_q;
        pending_d    = pending_q;

        // Clearing an idle warp is a no-op, so stray tokens need no extra check.
        if (done_hit) begin
            pending_d[done_warp] = 1'b0;
        end

        if (load_slot) begin
            if (sel_found) begin
                out_valid_d        = 1'b1;
                out_pc_d           = warp_pc[sel_idx*PC_WIDTH +: PC_WIDTH];
                out_warp_d         = sel_idx;
                out_split_d        = warp_split[sel_idx*SPLIT_WIDTH +: SPLIT_WIDTH];
                last_grant_d       = sel_idx;
                pending_d[sel_idx] = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_warp_q   <= '0;
            out_split_q  <= '0;
            pending_q    <= '0;
            last_grant_q <= WID_WIDTH'(WARP_NUM - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_warp_q   <= out_warp_d;
            out_split_q  <= out_split_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_warp  = out_warp_q;
    assign out_split = out_split_q;
    assign inflight  = pending_q;

`ifdef GELATO_FETCHARB_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;
    logic        stall_cycle;

    // A stall means work exists but nothing is eligible and no issue is showing.
    assign stall_cycle = rdy && !out_valid_q && (|warp_valid) && (eligible == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if (stall_cycle) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: doc/gelato_warp_fetch_arbiter.md
Name: gelato_warp_fetch_arbiter

Overview:
Parametrised round-robin warp arbiter between the PC table and the instruction fetch unit. It supports any warp count and per-warp in-flight tracking, so a warp is not re-issued until its fetch completes. The output is a registered valid/ready handshake that is held stable under backpressure. The fetch stage returns completion tokens that re-arm warps.

Parameters:
WARP_NUM, 8, number of warps; must be >= 2.
PC_WIDTH, 32, width of each PC.
SPLIT_WIDTH, 4, width of the split-table index per warp.
WID_WIDTH, $clog2(WARP_NUM), width of the warp index (derived; not overridden).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; low freezes arbitration
warp_valid  in  WARP_NUM  per-warp "has PC to fetch" from PC table
warp_pc  in  WARP_NUM*PC_WIDTH  packed PCs; warp i occupies bits [i*PC_WIDTH +: PC_WIDTH]
warp_split  in  WARP_NUM*SPLIT_WIDTH  packed split-table indices
out_valid  out  1  issue request to fetch unit
out_ready  in  1  fetch unit accepts
out_pc  out  PC_WIDTH  selected PC
out_warp  out  WID_WIDTH  selected warp
out_split  out  SPLIT_WIDTH  selected split index
done_valid  in  1  fetch completion for one warp
done_warp  in  WID_WIDTH  warp whose fetch completed
inflight  out  WARP_NUM  current pending mask (debug/observability)

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: out_valid=0, out_pc=0, out_warp=0, out_split=0, pending=0 (so inflight=0), last_grant=WARP_NUM-1. The first search therefore starts at warp 0.
- eligible = warp_valid & ~pending, using register values at the start of the cycle.
- Load slot: in a cycle with rdy=1 and (out_valid=0 or out_ready=1):
  - Search for the first eligible warp in the order last_grant+1, +2, …, wrapping modulo WARP_NUM. last_grant itself is checked last.
  - If one is found, then on the next edge: out_valid=1; out_pc/out_warp/out_split capture that warp's inputs; last_grant=w; pending[w]=1.
  - If none is found: out_valid=0, and out_pc/out_warp/out_split hold their previous values.
- Hold: when out_valid=1 and out_ready=0, all out_* signals stay stable and no new selection is made. This holds even if warp_valid or warp_pc of the held warp change.
- Accept and reload in the same cycle: out_valid&&out_ready with rdy=1 retires the current issue and loads the next choice in that same cycle. Back-to-back issue is 1 per cycle.
- Latency: eligibility at cycle t yields out_valid at t+1.
- Completion: done_valid=1 clears pending[done_warp] on the next edge. This is processed regardless of rdy.
  - A completion for a warp that is not pending is ignored.
  - done_warp >= WARP_NUM is ignored.
- Simultaneous clear and select: selection uses the pre-edge pending value. A warp receiving done in cycle t is first selectable in cycle t+1. A set and a clear can never target the same warp in one cycle, because a selected warp was not pending.
- rdy=0: no selection, out_* registers hold, last_grant holds; pending still clears on done.
- Single eligible warp equal to last_grant: it is re-selected, since starvation-free wrap includes self.
- Reset asserted mid-transaction: all state returns to reset values immediately. In-flight completions arriving after reset are ignored, because pending=0.

Optional Feature:
GELATO_FETCHARB_PERF_EN:
- When defined, adds outputs perf_issue_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_issue_cnt increments on every out_valid&&out_ready.
  - perf_stall_cnt increments on every cycle with rdy=1, out_valid=0 and |warp_valid=1, meaning work exists but every warp is pending.
  - Both counters wrap at 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then warp_valid=8'hFF, out_ready=1, done returned one cycle after each accept:
  - out_warp sequence is 0,1,2,…,7,0.
  - out_valid first goes high on the first clk edge after rst_n releases.
- warp_valid=8'b0010_0100 with no done: issues warp 2, then 5, then out_valid=0; inflight=8'b0010_0100.
- Backpressure: out_ready=0 for 4 cycles with warp 3 issued at PC 0x100, while warp_pc[3] is changed to 0x200. out_pc stays 0x100, out_warp stays 3, out_valid stays 1 until out_ready=1.
- Same-cycle done and select:
  - Only warp 1 is valid and pending; done_warp=1 is asserted at cycle t.
  - out_valid=0 at t+1; warp 1 is reissued with out_valid=1 at t+2.
- rdy=0 for 3 cycles with eligible warps and done_valid for a pending warp:
  - No change to out_*; that warp's inflight bit clears.
  - Arbitration resumes from last_grant+1 when rdy=1.
- With GELATO_FETCHARB_PERF_EN:
  - 5 accepts, then 3 cycles with all valid warps pending, gives perf_issue_cnt=5 and perf_stall_cnt=3.
  - Both counters read 0 after rst_n is asserted.
